// File: rtl/prescaler_if.sv
// Strobe bundle carried out of the prescaler: the single-cycle tick enable.
// The master side drives tick; consumers attach through the slave modport.
interface prescaler_if;
    logic tick;

    modport master (output tick);
    modport slave  (input  tick);
endinterface

// File: rtl/prescaler.sv
// Clock-enable generator: raises a registered, one-cycle tick once every SCALE
// rising clock edges so slow periodic logic can run off the system clock.
module prescaler #(
    parameter int SCALE      = 5,
    parameter int SCALE_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    prescaler_if.master tickIf
);

    localparam longint unsigned COUNT_RANGE = 64'd1 << SCALE_BITS;
    localparam logic [SCALE_BITS-1:0] LAST_COUNT = SCALE_BITS'(SCALE - 1);

    if ((SCALE < 1) || (longint'(SCALE) > longint'(COUNT_RANGE))) begin : gBadScale
        $fatal(1, "prescaler: SCALE must lie in 1..2**SCALE_BITS");
    end

    logic [SCALE_BITS-1:0] counter_q, counter_d;
    logic                  tick_q, tick_d;

    // Unreachable counts above LAST_COUNT wrap modulo 2**SCALE_BITS, no early tick.
    always_comb begin
        counter_d = counter_q + SCALE_BITS'(1);
        tick_d    = 1'b0;
        if (counter_q == LAST_COUNT) begin
            counter_d = '0;
            tick_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            tick_q    <= tick_d;
        end
    end

    assign tickIf.tick = tick_q;

endmodule

// File: tb/tb_prescaler.sv
// Bench for prescaler: three instances (SCALE 5, 1 and 8) share one clock and
// have independent resets so mid-count and during-tick resets can be exercised.
module tb_prescaler;

    typedef struct {
        int   edgeNum;
        logic e5;
        logic e1;
        logic e8;
    } vecT;

    typedef struct {
        logic e5;
        logic e1;
        logic e8;
    } expT;

    logic clock = 1'b0;
    logic rst5  = 1'b1;
    logic rst1  = 1'b1;
    logic rst8  = 1'b1;

    int checks = 0;
    int passes = 0;
    int n5 = 0;
    int n1 = 0;
    int n8 = 0;
    int pulses = 0;
    expT sb[$];
    vecT vecs[16];

    prescaler_if if5 ();
    prescaler_if if1 ();
    prescaler_if if8 ();

    prescaler #(.SCALE(5), .SCALE_BITS(3)) dut5 (.clock(clock), .reset(rst5), .tickIf(if5.master));
    prescaler #(.SCALE(1), .SCALE_BITS(1)) dut1 (.clock(clock), .reset(rst1), .tickIf(if1.master));
    prescaler #(.SCALE(8), .SCALE_BITS(3)) dut8 (.clock(clock), .reset(rst8), .tickIf(if8.master));

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        else
            passes++;
    endtask

    // Edge counters measure edges since each instance left reset.
    task automatic advanceEdge();
        @(posedge clock);
        n5++;
        n1++;
        n8++;
        #1;
    endtask

    task automatic applyStimulus(input string tag);
        expT e;
        expT got;
        e.e5 = ((n5 + 1) % 5 == 0);
        e.e1 = 1'b1;
        e.e8 = ((n8 + 1) % 8 == 0);
        sb.push_back(e);
        advanceEdge();
        got = sb.pop_front();
        checkOutput($sformatf("%s tick5 edge%0d", tag, n5), if5.tick, got.e5);
        checkOutput($sformatf("%s tick1 edge%0d", tag, n1), if1.tick, got.e1);
        checkOutput($sformatf("%s tick8 edge%0d", tag, n8), if8.tick, got.e8);
    endtask

    initial begin
        vecs = '{
            '{1,  1'b0, 1'b1, 1'b0}, '{2,  1'b0, 1'b1, 1'b0},
            '{3,  1'b0, 1'b1, 1'b0}, '{4,  1'b0, 1'b1, 1'b0},
            '{5,  1'b1, 1'b1, 1'b0}, '{6,  1'b0, 1'b1, 1'b0},
            '{7,  1'b0, 1'b1, 1'b0}, '{8,  1'b0, 1'b1, 1'b1},
            '{9,  1'b0, 1'b1, 1'b0}, '{10, 1'b1, 1'b1, 1'b0},
            '{11, 1'b0, 1'b1, 1'b0}, '{12, 1'b0, 1'b1, 1'b0},
            '{13, 1'b0, 1'b1, 1'b0}, '{14, 1'b0, 1'b1, 1'b0},
            '{15, 1'b1, 1'b1, 1'b0}, '{16, 1'b0, 1'b1, 1'b1}
        };

        // Power-up reset, released while the clock is low.
        #2;
        checkOutput("reset tick5", if5.tick, 1'b0);
        checkOutput("reset tick1", if1.tick, 1'b0);
        checkOutput("reset tick8", if8.tick, 1'b0);
        @(negedge clock);
        #1;
        rst5 = 1'b0;
        rst1 = 1'b0;
        rst8 = 1'b0;
        n5 = 0;
        n1 = 0;
        n8 = 0;
        #1;
        checkOutput("release tick5", if5.tick, 1'b0);
        checkOutput("release tick1", if1.tick, 1'b0);
        checkOutput("release tick8", if8.tick, 1'b0);

        // First periods, checked after each edge and again in the low phase.
        for (int i = 0; i < 16; i++) begin
            advanceEdge();
            checkOutput($sformatf("vec edge%0d tick5", vecs[i].edgeNum), if5.tick, vecs[i].e5);
            checkOutput($sformatf("vec edge%0d tick1", vecs[i].edgeNum), if1.tick, vecs[i].e1);
            checkOutput($sformatf("vec edge%0d tick8", vecs[i].edgeNum), if8.tick, vecs[i].e8);
            @(negedge clock);
            checkOutput($sformatf("vec edge%0d low tick5", vecs[i].edgeNum), if5.tick, vecs[i].e5);
        end

        // Periodicity over 50 cycles from a fresh release of the SCALE=5 instance.
        rst5 = 1'b1;
        #1;
        checkOutput("rearm tick5", if5.tick, 1'b0);
        rst5 = 1'b0;
        n5 = 0;
        for (int c = 0; c < 50; c++) begin
            applyStimulus("period");
            if (if5.tick === 1'b1) pulses++;
        end
        checkOutput("period pulse count", pulses, 10);

        // Mid-count reset after 3 edges: next tick needs 5 fresh edges.
        for (int c = 0; c < 3; c++) applyStimulus("precount");
        #2;
        rst5 = 1'b1;
        #1;
        checkOutput("midcount reset tick5", if5.tick, 1'b0);
        n5 = 0;
        #1;
        rst5 = 1'b0;
        for (int c = 0; c < 5; c++) applyStimulus("midcount");

        // Tick is high right now; reset must clear it without a clock edge.
        checkOutput("before reset tick5", if5.tick, 1'b1);
        #2;
        rst5 = 1'b1;
        #1;
        checkOutput("reset during tick5", if5.tick, 1'b0);
        n5 = 0;
        #1;
        rst5 = 1'b0;
        for (int c = 0; c < 12; c++) applyStimulus("restart");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/prescaler.md
Name: prescaler

Overview:
- Clock-enable generator. Divides the system clock by a constant SCALE.
- Emits a registered, single-cycle-wide `tick` pulse once every SCALE rising clock edges.
- Downstream logic uses `tick` as a synchronous enable for slow periodic events, e.g. timers, LED blink, baud or refresh pacing.
- Has no data path and no handshake.

Parameters:
- SCALE, default 5: division ratio. `tick` is high for 1 of every SCALE clock cycles. Legal range 1..2^SCALE_BITS.
- SCALE_BITS, default 3: width of the internal counter. Must satisfy 2^SCALE_BITS >= SCALE, so that SCALE-1 is representable.

Ports:
- clock, input, 1: system clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- tick, output, 1: registered strobe, high for exactly one clock cycle every SCALE cycles.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- State:
  - counter[SCALE_BITS-1:0].
  - tick register, driven directly from a flop with no combinational output path.
- Reset:
  - While reset=1: counter=0 and tick=0, immediately, without waiting for a clock edge.
  - Reset takes effect mid-count at any time and discards the partial count.
- Each rising edge of clock with reset=0:
  - If counter == SCALE-1: counter <= 0 and tick <= 1.
  - Otherwise: counter <= counter+1 and tick <= 0.
- Latency after reset release:
  - The first tick is asserted by the SCALE-th rising edge.
  - It is visible after that edge and stays high until the (SCALE+1)-th edge, which clears it.
  - Edges 1..SCALE-1 leave tick=0.
- Steady state:
  - tick is high for exactly 1 cycle, then low for SCALE-1 cycles, repeating.
  - Period is exactly SCALE cycles, with no drift.
- SCALE=1: tick=0 during reset, then high continuously from the first edge onward.
- Counter wrap:
  - The counter never exceeds SCALE-1.
  - Values SCALE..2^SCALE_BITS-1 are unreachable. If one is ever present, the counter still increments and wraps naturally modulo 2^SCALE_BITS, and no tick fires until it reaches SCALE-1.
- Timing:
  - Sampling tick in the same simulation timestep as a rising edge (before nonblocking updates) returns the pre-edge value.
  - The new value is valid after the edge.
- Reset release coinciding with a clock edge: that edge is ignored. Counting begins on the next edge.
- Elaboration check: if SCALE < 1 or SCALE > 2^SCALE_BITS, raise a simulation error/fatal.

Test Plan:
1. Power-up reset.
   - Stimulus: SCALE=5, SCALE_BITS=3. Assert reset, then release with clock low.
   - Required: tick=0 during reset and immediately after release, before any edge.
2. First period.
   - Stimulus: after release, apply edges 1..4.
   - Required: tick=0 after each edge.
   - Stimulus: apply edge 5.
   - Required: tick still reads 0 in the edge's timestep, reads 1 by the next timestep, and stays 1 through the low phase.
   - Stimulus: apply edge 6.
   - Required: tick=0, and stays 0 through edges 7..9.
3. Periodicity.
   - Stimulus: run 50 cycles with SCALE=5.
   - Required: tick high on exactly cycles 5, 10, …, 50 after release (10 pulses), each exactly 1 cycle wide.
4. Mid-count reset.
   - Stimulus: assert reset asynchronously (between edges) after 3 edges, then release.
   - Required: tick=0 at once; the next tick appears after 5 further edges, not 2.
5. Reset during tick.
   - Stimulus: assert reset while tick=1.
   - Required: tick drops to 0 immediately, with no clock edge needed.
6. Edge ratios.
   - Stimulus: SCALE=1, SCALE_BITS=1.
   - Required: tick=1 every cycle after the first edge.
   - Stimulus: SCALE=8, SCALE_BITS=3, full counter range.
   - Required: one pulse every 8 cycles.
